// File: rtl/serie_paralelo_pkg.sv
// rtl/serie_paralelo_pkg.sv - shared types and constants for the serial-to-parallel deserialiser
//
// Purpose : FSM state encoding and the default alignment comma shared by
//           serie_paralelo_n and sp_comma_det.
// Contents: state_t (HUNT/ALIGN/LOCKED), SP_COMMA_DEFAULT.
package serie_paralelo_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        ALIGN  = 2'b01,
        LOCKED = 2'b10
    } state_t;

    localparam logic [7:0] SP_COMMA_DEFAULT = 8'hBC;

endpackage

// File: rtl/sp_comma_det.sv
// rtl/sp_comma_det.sv - combinational comma detector for the deserialiser shift register
//
// Purpose : Compares the shift register against the comma symbol, honouring
//           the current polarity selection. With SERIE_PARALELO_N_POLARITY_EN
//           defined it also flags an inverted comma seen on a non-inverted line.
// Ports   : shreg_i     - current shift register contents
//           pol_inv_i   - 1 when the line is being received inverted
//           comma_hit_o - (possibly inverted) word equals COMMA
//           inv_hit_o   - raw word equals ~COMMA (0 when the macro is undefined)
module sp_comma_det
    import serie_paralelo_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = WIDTH'(SP_COMMA_DEFAULT)
) (
    input  logic [WIDTH-1:0] shreg_i,
    input  logic             pol_inv_i,
    output logic             comma_hit_o,
    output logic             inv_hit_o
);

    logic [WIDTH-1:0] word;

    assign word        = pol_inv_i ? ~shreg_i : shreg_i;
    assign comma_hit_o = (word == COMMA);

`ifdef SERIE_PARALELO_N_POLARITY_EN
    // Only meaningful before polarity is decided; once inverted, the
    // inverted comma is reported through comma_hit_o instead.
    assign inv_hit_o = !pol_inv_i && (shreg_i == ~COMMA);
`else
    assign inv_hit_o = 1'b0;
`endif

endmodule

// File: rtl/serie_paralelo_n.sv
// rtl/serie_paralelo_n.sv - comma-aligned serial-to-parallel deserialiser with lock FSM
//
// Purpose : Shifts in one bit per clk_8f (MSB first), hunts for the comma
//           symbol, locks after LOCK_COUNT aligned commas and then emits each
//           non-comma word with a one-cycle valid pulse. Repeated off-boundary
//           commas while locked force a relock.
// Config  : SERIE_PARALELO_N_POLARITY_EN - also lock onto an inverted comma and
//           receive the line inverted from then on (polarity_inv = 1).
// Ports   : clk_8f       - bit-rate clock
//           reset        - synchronous active-high reset
//           data_in      - serial data
//           data_out     - last deserialised non-comma word
//           valid_out    - one-cycle pulse qualifying data_out
//           active       - FSM is LOCKED
//           comma_cnt    - aligned commas counted toward lock
//           polarity_inv - line received inverted
module serie_paralelo_n
    import serie_paralelo_pkg::*;
#(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] COMMA        = WIDTH'(SP_COMMA_DEFAULT),
    parameter int unsigned      LOCK_COUNT   = 4,
    parameter int unsigned      MISALIGN_MAX = 3
) (
    input  logic                            clk_8f,
    input  logic                            reset,
    input  logic                            data_in,
    output logic [WIDTH-1:0]                data_out,
    output logic                            valid_out,
    output logic                            active,
    output logic [$clog2(LOCK_COUNT+1)-1:0] comma_cnt,
    output logic                            polarity_inv
);

    localparam int unsigned PH_W  = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MIS_W = $clog2(MISALIGN_MAX + 1);

    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LOCK  = CNT_W'(LOCK_COUNT);
    localparam logic [MIS_W-1:0] MIS_LIMIT = MIS_W'(MISALIGN_MAX);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MIS_W-1:0] mis_q, mis_d;
    logic             valid_q, valid_d;
    logic             pol_q, pol_d;
    logic             comma_hit;
    logic             inv_hit;
    logic             boundary;

    sp_comma_det #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_comma_det (
        .shreg_i     (shreg_q),
        .pol_inv_i   (pol_q),
        .comma_hit_o (comma_hit),
        .inv_hit_o   (inv_hit)
    );

    assign word     = pol_q ? ~shreg_q : shreg_q;
    assign boundary = (phase_q == '0);

    always_comb begin
        state_d    = state_q;
        phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        cnt_d      = cnt_q;
        mis_d      = mis_q;
        valid_d    = 1'b0;
        data_out_d = data_out_q;
        pol_d      = pol_q;

        case (state_q)
            HUNT: begin
                pol_d = 1'b0;
                if (comma_hit || inv_hit) begin
                    // This cycle is the comma's boundary, so the next is phase 1.
                    phase_d = PH_W'(1);
                    cnt_d   = CNT_W'(1);
                    mis_d   = '0;
                    pol_d   = inv_hit && !comma_hit;
                    state_d = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
                end
            end

            ALIGN: begin
                if (boundary) begin
                    if (comma_hit) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_LOCK) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        cnt_d   = '0;
                        pol_d   = 1'b0;
                        state_d = HUNT;
                    end
                end
            end

            LOCKED: begin
                if (boundary) begin
                    if (comma_hit) begin
                        mis_d = '0;
                    end else begin
                        data_out_d = word;
                        valid_d    = 1'b1;
                    end
                end else if (comma_hit) begin
                    if (mis_q + MIS_W'(1) == MIS_LIMIT) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                        mis_d   = '0;
                        pol_d   = 1'b0;
                    end else begin
                        mis_d = mis_q + MIS_W'(1);
                    end
                end
            end

            default: begin
                state_d = HUNT;
                cnt_d   = '0;
                mis_d   = '0;
                pol_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state_q    <= HUNT;
            shreg_q    <= '0;
            phase_q    <= '0;
            cnt_q      <= '0;
            mis_q      <= '0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
            pol_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= {shreg_q[WIDTH-2:0], data_in};
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            mis_q      <= mis_d;
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
            pol_q      <= pol_d;
        end
    end

    assign data_out  = data_out_q;
    // Qualified by state so a pulse can never escape once LOCKED is left.
    assign valid_out = valid_q && (state_q == LOCKED);
    assign active    = (state_q == LOCKED);
    assign comma_cnt = cnt_q;

`ifdef SERIE_PARALELO_N_POLARITY_EN
    assign polarity_inv = pol_q;
`else
    assign polarity_inv = 1'b0;
`endif

endmodule
